and_gate_arbiter: RTL and testbench
===================================

// Module: and_gate_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer sharing one 2-input AND evaluation unit among
//   NREQ requesters. Captures the winner's operands, holds the shared unit for
//   HOLD cycles, then returns the result with a one-hot done pulse. Sits between
//   the requesting logic blocks and the single and_gate instance it wraps.
// PARAMETERS
//   NREQ  4  number of requesters, legal 2..8
//   HOLD  2  cycles the shared unit is occupied per operation, legal 1..15
// PORTS
//   clk    in   1     clock, all state on rising edge
//   rst_n  in   1     asynchronous active-low reset
//   req    in   NREQ  per-requester request; held high until own gnt bit seen
//   a      in   NREQ  per-requester operand A (bit i belongs to requester i)
//   b      in   NREQ  per-requester operand B
//   gnt    out  NREQ  one-hot, 1-cycle pulse: request accepted, operands captured
//   done   out  NREQ  one-hot, 1-cycle pulse: result on y belongs to requester i
//   y      out  1     result a&b of the completed operation; held between ops
//   busy   out  1     high whenever state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, gnt=0, done=0, y=0, busy=0, ptr=0,
//     cnt=0, operand latches=0. Reset mid-operation aborts; no done is issued.
//   States: IDLE -> BUSY -> DONE -> IDLE. All outputs registered; busy decoded
//     from the state register only.
//   IDLE: at an edge with req!=0, winner = first set bit of req searching from
//     ptr upward, wrapping NREQ-1 -> 0. At that edge: gnt<=onehot(winner),
//     a_lat<=a[winner], b_lat<=b[winner], idx<=winner, ptr<=(winner+1)%NREQ,
//     cnt<=HOLD-1, state<=BUSY. req==0: stay IDLE, outputs low.
//   BUSY: gnt<=0 at first edge. cnt==0 -> done<=onehot(idx), y<=a_lat&b_lat,
//     state<=DONE; else cnt<=cnt-1. req ignored during BUSY and DONE.
//   DONE: done<=0, state<=IDLE. No grant issued in the DONE cycle.
//   Latency: req sampled at edge E0 -> gnt high E0..E1 -> done and y valid
//     E(HOLD)..E(HOLD+1). Earliest next grant at edge E(HOLD+2);
//     max throughput one op per HOLD+2 cycles.
//   Fairness: a requester holding req high is granted within NREQ operations.
//     Last winner has lowest priority next round.
//   Simultaneous: all req bits high with ptr=k -> requester k wins.
//     A requester may reassert req in the DONE cycle and compete in the next IDLE.
//   Operands sampled only at the grant edge; later changes to a/b never affect y.
//   ptr wraps modulo NREQ. Index registers are sized by $clog2(NREQ).
//   y changes only at the BUSY->DONE edge or at reset.
// TESTING
//   1 Reset: rst_n=0 with req=4'b1111 -> gnt=0, done=0, y=0, busy=0.
//     Release -> first grant is 4'b0001.
//   2 Single op, HOLD=2: req[2]=1, a[2]=1, b[2]=1 at E0 -> gnt=4'b0100 after E0,
//     done=4'b0100 and y=1 after E2, busy low after E3.
//   3 Round-robin: req=4'b1111 held continuously -> grant order 0,1,2,3,0.
//     Gap of HOLD+2 cycles between successive gnt pulses.
//   4 Operand capture: a[1]=1, b[1]=0 granted, then both flip to 1 while BUSY ->
//     y=0 with done[1].
//   5 Reset mid-op: assert rst_n=0 while BUSY with cnt=1 -> no done pulse, y=0,
//     ptr=0. Next req=4'b1000 -> gnt=4'b1000.
//   6 Wrap/skip: ptr=3, req=4'b0110 -> requester 1 wins, ptr becomes 2.
//     Next contest with req=4'b0110 -> requester 2 wins.

Source files
------------

// File: rtl/and_gate_arbiter_if.sv
// Request/grant/result bundle between NREQ requesters and the shared AND arbiter.
// The master side drives requests and operands; the slave side is the arbiter.
interface and_gate_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] a;
  logic [NREQ-1:0] b;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            y;
  logic            busy;

  modport master (
    output req, a, b,
    input  gnt, done, y, busy
  );

  modport slave (
    input  req, a, b,
    output gnt, done, y, busy
  );
endinterface

// File: rtl/and_gate_arbiter.sv
// Round-robin sequencer sharing one 2-input AND unit among NREQ requesters.
// A winner's operands are captured at grant, held HOLD cycles, then returned with done.
module and_gate_arbiter #(
  parameter int NREQ = 4,
  parameter int HOLD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  and_gate_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [3:0]      r_cnt;
  logic            r_a_lat;
  logic            r_b_lat;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_y;

  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_ptr_nxt;
  logic            w_and;

  // Scan from ptr upward with wrap; descending loop lets the nearest hit win.
  function automatic logic [IW:0] find_winner(input logic [NREQ-1:0] req,
                                              input logic [IW-1:0]   ptr);
    logic [IW:0] res;
    int          k;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NREQ;
      if (req[k]) res = {1'b1, IW'(k)};
    end
    return res;
  endfunction

  assign {w_found, w_win} = find_winner(bus.req, r_ptr);
  assign w_ptr_nxt        = (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;

  // The shared evaluation unit: a single AND on the latched operands.
  assign w_and = r_a_lat & r_b_lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_a_lat <= 1'b0;
      r_b_lat <= 1'b0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_y     <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt[w_win] <= 1'b1;
            r_a_lat      <= bus.a[w_win];
            r_b_lat      <= bus.b[w_win];
            r_idx        <= w_win;
            r_ptr        <= w_ptr_nxt;
            r_cnt        <= 4'(HOLD - 1);
            r_state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_done[r_idx] <= 1'b1;
            r_y           <= w_and;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.done = r_done;
  assign bus.y    = r_y;
  assign bus.busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_and_gate_arbiter.sv
// Self-checking bench for and_gate_arbiter: directed table, corner sequences,
// and randomized transactions against a transaction-level round-robin model.
module tb_and_gate_arbiter;

  localparam int NREQ = 4;
  localparam int HOLD = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   m_ptr;
  logic m_y;

  and_gate_arbiter_if #(.NREQ(NREQ)) bus ();

  and_gate_arbiter #(.NREQ(NREQ), .HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] b;
    int         exp_w;
    logic       exp_y;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference winner: first set bit at or after p, wrapping around.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // One full transaction from IDLE; operands change to a1/b1 right after grant.
  task automatic do_op(input logic [3:0] r, input logic [3:0] a0, input logic [3:0] b0,
                       input logic [3:0] a1, input logic [3:0] b1,
                       input int ew, input logic ey);
    bus.req = r;
    bus.a   = a0;
    bus.b   = b0;
    step();
    chk("gnt", {28'd0, bus.gnt}, 32'd1 << ew);
    chk("busy_at_gnt", {31'd0, bus.busy}, 32'd1);
    chk("done_at_gnt", {28'd0, bus.done}, 32'd0);
    bus.req = 4'b0000;
    bus.a   = a1;
    bus.b   = b1;
    for (int i = 0; i < HOLD - 1; i++) begin
      step();
      chk("gnt_pulse", {28'd0, bus.gnt}, 32'd0);
      chk("done_early", {28'd0, bus.done}, 32'd0);
      chk("y_held", {31'd0, bus.y}, {31'd0, m_y});
    end
    step();
    chk("done", {28'd0, bus.done}, 32'd1 << ew);
    chk("y", {31'd0, bus.y}, {31'd0, ey});
    m_y = ey;
    step();
    chk("done_pulse", {28'd0, bus.done}, 32'd0);
    chk("busy_after", {31'd0, bus.busy}, 32'd0);
    chk("y_after", {31'd0, bus.y}, {31'd0, ey});
    m_ptr = (ew + 1) % NREQ;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_ptr    = 0;
    m_y      = 1'b0;

    vecs[0] = '{4'b0100, 4'b0100, 4'b0100, 2, 1'b1};
    vecs[1] = '{4'b0110, 4'b0000, 4'b1111, 1, 1'b0};
    vecs[2] = '{4'b0110, 4'b0100, 4'b0100, 2, 1'b1};
    vecs[3] = '{4'b1111, 4'b1000, 4'b0000, 3, 1'b0};
    vecs[4] = '{4'b1111, 4'b0001, 4'b0001, 0, 1'b1};
    vecs[5] = '{4'b1010, 4'b0010, 4'b0010, 1, 1'b1};
    vecs[6] = '{4'b0001, 4'b1111, 4'b1110, 0, 1'b0};
    vecs[7] = '{4'b1001, 4'b1000, 4'b1000, 3, 1'b1};

    // Reset with all requests asserted.
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    bus.a   = 4'b1111;
    bus.b   = 4'b1111;
    step();
    step();
    chk("rst_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("rst_done", {28'd0, bus.done}, 32'd0);
    chk("rst_y", {31'd0, bus.y}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    do_op(4'b1111, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 1'b1);

    // Directed table, starting from a fresh reset so ptr=0.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_ptr = 0;
    m_y   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("model_vs_table", pick(vecs[i].req, m_ptr), vecs[i].exp_w);
      do_op(vecs[i].req, vecs[i].a, vecs[i].b, ~vecs[i].a, ~vecs[i].b,
            vecs[i].exp_w, vecs[i].exp_y);
    end

    // Operand capture: flips after grant must not reach y.
    begin
      int w;
      w = pick(4'b0010, m_ptr);
      do_op(4'b0010, 4'b0010, 4'b0000, 4'b1111, 4'b1111, w, 1'b0);
    end

    // Round-robin with req held continuously: order and gnt spacing.
    begin
      int last_t;
      int cyc;
      int n_seen;
      logic got;
      bus.req = 4'b1111;
      bus.a   = 4'b0000;
      bus.b   = 4'b0000;
      last_t  = -1;
      cyc     = 0;
      n_seen  = 0;
      while (n_seen < 5 && cyc < 40) begin
        step();
        cyc++;
        got = (bus.gnt != 4'b0000);
        if (got) begin
          chk("rr_order", {28'd0, bus.gnt}, 32'd1 << m_ptr);
          if (last_t >= 0) chk("rr_gap", cyc - last_t, HOLD + 2);
          last_t = cyc;
          m_ptr  = (m_ptr + 1) % NREQ;
          n_seen++;
        end
      end
      chk("rr_count", n_seen, 5);
      bus.req = 4'b0000;
      cyc = 0;
      while (bus.busy !== 1'b0 && cyc < 20) begin
        step();
        cyc++;
      end
      chk("rr_drain", {31'd0, bus.busy}, 32'd0);
      m_y = 1'b0;
    end

    // Reset mid-operation: no done, ptr back to 0.
    bus.req = 4'b0100;
    bus.a   = 4'b0100;
    bus.b   = 4'b0100;
    step();
    chk("mid_gnt", {28'd0, bus.gnt}, 32'd1 << pick(4'b0100, m_ptr));
    bus.req = 4'b0000;
    rst_n   = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_gnt", {28'd0, bus.gnt}, 32'd0);
    for (int i = 0; i < HOLD + 1; i++) begin
      step();
      chk("mid_rst_done", {28'd0, bus.done}, 32'd0);
      chk("mid_rst_y", {31'd0, bus.y}, 32'd0);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    m_y   = 1'b0;
    do_op(4'b0110, 4'b0010, 4'b0010, 4'b0000, 4'b0000, pick(4'b0110, m_ptr), 1'b1);
    do_op(4'b1000, 4'b1000, 4'b0000, 4'b1111, 4'b1111, 3, 1'b0);

    // Randomized transactions against the model.
    for (int n = 0; n < 60; n++) begin
      logic [3:0] r, a0, b0, a1, b1;
      int w;
      r  = 4'($urandom_range(0, 15));
      a0 = 4'($urandom);
      b0 = 4'($urandom);
      a1 = 4'($urandom);
      b1 = 4'($urandom);
      if (r == 4'b0000) begin
        bus.req = r;
        bus.a   = a0;
        bus.b   = b0;
        step();
        chk("idle_gnt", {28'd0, bus.gnt}, 32'd0);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_y", {31'd0, bus.y}, {31'd0, m_y});
      end else begin
        w = pick(r, m_ptr);
        do_op(r, a0, b0, a1, b1, w, a0[w] & b0[w]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
